// File: rtl/icebreaker_lite_mem_arbiter.sv
// Two-master memory arbiter: the instruction bus (read-only) and the data bus (read/write)
// share one single-port word memory with a 1-cycle registered read path.
// Every access is an IDLE (issue) cycle followed by a RESP (ack) cycle.
// Out-of-range accesses are acknowledged without enabling the memory.
module icebreaker_lite_mem_arbiter #(
  parameter int unsigned MEM_WORDS     = 1024,
  parameter bit          DATA_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_en,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned LW = AW + 1;
  // One extra bit so MEM_WORDS*4 cannot wrap; compare is on the full byte address.
  localparam logic [LW-1:0] ADDR_LIMIT = LW'(MEM_WORDS) << 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  typedef enum logic {
    M_INSTR = 1'b0,
    M_DATA  = 1'b1
  } master_t;

  state_t          r_state;
  state_t          w_next_state;
  master_t         r_grant;
  master_t         r_last_grant;
  logic            r_oor;
  logic            r_is_wr;
  logic [AW-1:0]   r_hold_addr;
  logic [DW-1:0]   r_hold_wdata;
  logic [MW-1:0]   r_hold_mask;

  master_t         w_sel;
  logic            w_any_req;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [MW-1:0]   w_sel_mask;
  logic            w_sel_wr;
  logic            w_in_range;
  logic            w_issue;
  logic [DW-1:0]   w_rd;

  assign w_any_req = instr_req | data_req;
  assign w_issue   = (r_state == S_IDLE) && w_any_req;

  // Pick the master to serve: sole requester, else priority or round-robin on conflict.
  always_comb begin
    w_sel = M_INSTR;
    if (data_req && !instr_req) begin
      w_sel = M_DATA;
    end else if (data_req && instr_req) begin
      if (DATA_PRIORITY) begin
        w_sel = M_DATA;
      end else begin
        w_sel = (r_last_grant == M_DATA) ? M_INSTR : M_DATA;
      end
    end
  end

  // Mux the selected master's request fields; the instruction bus never writes.
  always_comb begin
    w_sel_addr  = instr_addr;
    w_sel_wdata = '0;
    w_sel_mask  = '0;
    w_sel_wr    = 1'b0;
    if (w_sel == M_DATA) begin
      w_sel_addr  = data_addr;
      w_sel_wdata = data_wr_data;
      w_sel_mask  = data_mask;
      w_sel_wr    = data_wr_en;
    end
    w_in_range = {1'b0, w_sel_addr} < ADDR_LIMIT;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, memory port drive and ack/read-data decode.
  always_comb begin
    w_next_state = r_state;
    mem_addr     = r_hold_addr;
    mem_wdata    = r_hold_wdata;
    mem_wr_mask  = r_hold_mask;
    mem_en       = 1'b0;
    mem_wr_en    = 1'b0;
    instr_ack    = 1'b0;
    data_ack     = 1'b0;
    instr_data   = '0;
    data_rd_data = '0;
    w_rd         = (r_oor || r_is_wr) ? '0 : mem_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          mem_addr     = w_sel_addr;
          mem_wdata    = w_sel_wdata;
          mem_wr_mask  = w_sel_mask;
          // Reset has priority: never let a request reach the memory while rstz is low.
          mem_en       = w_in_range && rstz;
          mem_wr_en    = w_sel_wr && rstz;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
        // A reset landing on the response cycle swallows the ack; the master retries.
        if (rstz) begin
          if (r_grant == M_INSTR) begin
            instr_ack  = 1'b1;
            instr_data = w_rd;
          end else begin
            data_ack     = 1'b1;
            data_rd_data = w_rd;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Transaction context captured at issue, consumed during the response cycle.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      r_grant      <= M_INSTR;
      r_last_grant <= M_DATA;
      r_oor        <= 1'b0;
      r_is_wr      <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_hold_mask  <= '0;
    end else if (w_issue) begin
      r_grant      <= w_sel;
      r_last_grant <= w_sel;
      r_oor        <= !w_in_range;
      r_is_wr      <= w_sel_wr;
      r_hold_addr  <= w_sel_addr;
      r_hold_wdata <= w_sel_wdata;
      r_hold_mask  <= w_sel_mask;
    end
  end

endmodule
